mat_result_streamer: RTL and testbench
======================================

MAT_RESULT_STREAMER -- requirements
Module: mat_result_streamer

Interface
REQ-001 Parameter MAX_SIZE, default 13, meaning matrix dimension (rows = cols).
REQ-002 Parameter DATA_BW, default 16, meaning source element width; result elements are 2*DATA_BW bits.
REQ-003 Parameter SQU_MAX_SIZE, default 169, meaning element count (MAX_SIZE*MAX_SIZE).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 finish_in  input  1  level "result ready" flag from the multiplier; stays high until the multiplier is reset.
REQ-007 data_in  input  SQU_MAX_SIZE*DATA_BW*2  packed result matrix; element e at bits [e*2*DATA_BW +: 2*DATA_BW], row-major (e = row*MAX_SIZE+col).
REQ-008 m_valid  output  1  stream element valid.
REQ-009 m_ready  input  1  downstream accepts the element.
REQ-010 m_data  output  2*DATA_BW  current element value.
REQ-011 m_row  output  4  row index of m_data.
REQ-012 m_col  output  4  column index of m_data.
REQ-013 m_last  output  1  high with the final element of the matrix.
REQ-014 busy  output  1  high while in STREAM.
REQ-015 done  output  1  one-cycle pulse after the last element is accepted.

Function
REQ-016 FSM states SHALL be IDLE, STREAM, DONE.
REQ-017 A rising edge on finish_in (sampled high, previous sample low) in IDLE SHALL, at that clock edge, copy all of data_in into an internal SQU_MAX_SIZE x 2*DATA_BW buffer, clear the element index and enter STREAM.
REQ-018 m_valid SHALL be high in every STREAM cycle and low in IDLE and DONE; first m_valid is the cycle after the finish_in rise is sampled.
REQ-019 A transfer occurs on a cycle with m_valid and m_ready both high; the index SHALL advance by one per transfer and never otherwise.
REQ-020 While m_valid is high and m_ready is low, m_data, m_row, m_col and m_last SHALL hold stable.
REQ-021 m_row and m_col SHALL track the index (col wraps 0..MAX_SIZE-1 then row increments); m_data is the buffered element at the emitted position.
REQ-022 m_last SHALL be high exactly when the emitted element is the final one (index SQU_MAX_SIZE-1).
REQ-023 The transfer of the m_last element SHALL move the FSM to DONE; DONE asserts done for one cycle, then returns to IDLE.
REQ-024 finish_in edges during STREAM or DONE SHALL be ignored; data_in changes after capture SHALL not affect the output.
REQ-025 A new run SHALL require finish_in to be sampled low then high again; finish_in held high after a run SHALL not restart streaming.
REQ-026 finish_in already high when rst deasserts SHALL count as a rising edge (previous-sample register resets to 0).
REQ-027 A full matrix with m_ready held high SHALL take exactly SQU_MAX_SIZE STREAM cycles.

Reset
REQ-028 On rst: state IDLE, index 0, previous finish sample 0, m_valid 0, m_data 0, m_row 0, m_col 0, m_last 0, busy 0, done 0.
REQ-029 rst asserted mid-STREAM SHALL abort the run; m_valid is low the cycle after the reset edge and the partially sent matrix is discarded.
REQ-030 The capture buffer need not be cleared by reset.

Configuration
REQ-031 Macro MAT_STREAM_TRANSPOSE_EN: when defined, the stream order SHALL be column-major (row increments fastest; element emitted at step t has row = t mod MAX_SIZE, col = t / MAX_SIZE), with m_row/m_col reporting the true position.
REQ-032 Without MAT_STREAM_TRANSPOSE_EN, the order SHALL be row-major per REQ-021; m_last is the final step in either mode (element (MAX_SIZE-1, MAX_SIZE-1) in both).

Verification
REQ-033 data_in element e = e+1000, finish_in rises, m_ready=1 -> 169 beats, m_data 1000..1168, m_row/m_col 0,0..12,12, m_last only on beat 169, done pulse the next cycle.
REQ-034 Same stimulus, m_ready toggles 1/0 each cycle -> identical sequence; outputs stable on every m_ready=0 cycle; 337 STREAM cycles.
REQ-035 finish_in held high after done -> no second run; drop low one cycle then high -> second identical run.
REQ-036 rst pulsed after beat 50 -> m_valid 0 next cycle; new finish_in rise -> restart from element 0 (value 1000).
REQ-037 data_in changed to all 0xFFFFFFFF during STREAM -> streamed values remain 1000.. series.
REQ-038 With MAT_STREAM_TRANSPOSE_EN defined -> beat 2 is m_row=1, m_col=0, m_data=1013; beat 14 is m_row=0, m_col=1, m_data=1001; beat 169 is m_row=12, m_col=12, m_data=1168 with m_last=1.

Source files
------------

// File: rtl/mat_result_streamer.sv
// Captures a finished result matrix on the rising edge of finish_in and streams it out element by element over a valid/ready handshake.
// Optional macro MAT_STREAM_TRANSPOSE_EN switches the stream order from row-major to column-major.
module mat_result_streamer #(
    parameter int MAX_SIZE     = 13,
    parameter int DATA_BW      = 16,
    parameter int SQU_MAX_SIZE = 169
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               finish_in,
    input  logic [SQU_MAX_SIZE*DATA_BW*2-1:0]  data_in,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [2*DATA_BW-1:0]               m_data,
    output logic [3:0]                         m_row,
    output logic [3:0]                         m_col,
    output logic                               m_last,
    output logic                               busy,
    output logic                               done
);

    localparam int EW    = 2 * DATA_BW;
    localparam int IDX_W = $clog2(SQU_MAX_SIZE);

    localparam logic [3:0]       LAST_POS   = 4'(MAX_SIZE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SQU_MAX_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] ROW_STRIDE = IDX_W'(MAX_SIZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    logic              fin_prev_r;
    logic              start_s;
    logic              xfer_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_s;
    logic [IDX_W-1:0]  addr_r;
    logic [IDX_W-1:0]  addr_s;
    logic [3:0]        row_s;
    logic [3:0]        col_s;
    logic [EW-1:0]     cap_mem_r [SQU_MAX_SIZE];

    // Only an IDLE-state rising edge of finish_in starts a run; m_valid mirrors STREAM.
    assign start_s = (state_r == IDLE) && finish_in && !fin_prev_r;
    assign xfer_s  = m_valid && m_ready;

    // State register and previous finish_in sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            fin_prev_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            fin_prev_r <= finish_in;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = STREAM;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (xfer_s && m_last) begin
                    state_s = DONE;
                end else begin
                    state_s = STREAM;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next stream position: step index, buffer address and reported row/col.
    always_comb begin
        idx_s  = idx_r;
        addr_s = addr_r;
        row_s  = m_row;
        col_s  = m_col;
        if (start_s) begin
            idx_s  = '0;
            addr_s = '0;
            row_s  = 4'd0;
            col_s  = 4'd0;
        end else if (xfer_s && !m_last) begin
            idx_s = idx_r + IDX_ONE;
`ifdef MAT_STREAM_TRANSPOSE_EN
            if (m_row == LAST_POS) begin
                row_s  = 4'd0;
                col_s  = m_col + 4'd1;
                addr_s = IDX_W'(m_col + 4'd1);
            end else begin
                row_s  = m_row + 4'd1;
                addr_s = addr_r + ROW_STRIDE;
            end
`else
            if (m_col == LAST_POS) begin
                col_s = 4'd0;
                row_s = m_row + 4'd1;
            end else begin
                col_s = m_col + 4'd1;
            end
            addr_s = addr_r + IDX_ONE;
`endif
        end else begin
            idx_s  = idx_r;
            addr_s = addr_r;
        end
    end

    // Snapshot of the whole result matrix, taken only at the start of a run.
    always_ff @(posedge clk) begin
        if (start_s) begin
            for (int e = 0; e < SQU_MAX_SIZE; e++) begin
                cap_mem_r[e] <= data_in[e*EW +: EW];
            end
        end
    end

    // Registered stream outputs; element 0 bypasses the buffer on the capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= '0;
            addr_r  <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_row   <= 4'd0;
            m_col   <= 4'd0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            idx_r   <= idx_s;
            addr_r  <= addr_s;
            m_valid <= (state_s == STREAM);
            busy    <= (state_s == STREAM);
            done    <= (state_s == DONE);
            m_row   <= row_s;
            m_col   <= col_s;
            m_last  <= (state_s == STREAM) && (idx_s == LAST_IDX);
            m_data  <= start_s ? data_in[EW-1:0] : cap_mem_r[addr_s];
        end
    end

endmodule

// File: tb/tb_mat_result_streamer.sv
// Randomized self-checking bench for mat_result_streamer; expected beats come from a matrix-order model.
// Honours MAT_STREAM_TRANSPOSE_EN to select the expected stream order.
module tb_mat_result_streamer;

    localparam int N    = 13;
    localparam int DW   = 16;
    localparam int SQU  = 169;
    localparam int EW   = 2 * DW;
    localparam int OUTW = 1 + 1 + EW + 4 + 4 + 1;

    logic                  clk;
    logic                  rst;
    logic                  finish_in;
    logic [SQU*EW-1:0]     data_in;
    logic                  m_valid;
    logic                  m_ready;
    logic [EW-1:0]         m_data;
    logic [3:0]            m_row;
    logic [3:0]            m_col;
    logic                  m_last;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] mat      [SQU];
    logic [EW-1:0] exp_data [SQU];
    logic [3:0]    exp_row  [SQU];
    logic [3:0]    exp_col  [SQU];
    logic          exp_last [SQU];

    mat_result_streamer #(.MAX_SIZE(N), .DATA_BW(DW), .SQU_MAX_SIZE(SQU)) dut (
        .clk(clk), .rst(rst), .finish_in(finish_in), .data_in(data_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
        .m_col(m_col), .m_last(m_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_matrix(input bit random_vals);
        for (int e = 0; e < SQU; e++) begin
            mat[e] = random_vals ? EW'($urandom) : EW'(e + 1000);
            data_in[e*EW +: EW] = mat[e];
        end
    endtask

    // Expected beat t: position from plain div/mod on t, value from the matrix at that position.
    task automatic build_expected();
        int r, c;
        for (int t = 0; t < SQU; t++) begin
`ifdef MAT_STREAM_TRANSPOSE_EN
            r = t % N;
            c = t / N;
`else
            r = t / N;
            c = t % N;
`endif
            exp_row[t]  = 4'(r);
            exp_col[t]  = 4'(c);
            exp_data[t] = mat[r*N + c];
            exp_last[t] = (t == SQU - 1);
        end
    endtask

    // mode 0: ready always; 1: ready toggles starting high; 2: random ready and finish_in noise.
    task automatic run_stream(input int mode, input int abort_at, input bit corrupt, input string name);
        int beat, cyc;
        bit rdy, stalled;
        logic [OUTW-1:0] obs, held, expv;
        build_expected();
        m_ready   = 1'b0;
        finish_in = 1'b0;
        @(negedge clk);
        finish_in = 1'b1;
        @(negedge clk);
        beat = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (beat < SQU && cyc < 4*SQU) begin
            if (beat == abort_at) begin
                rst = 1'b1; finish_in = 1'b0; m_ready = 1'b0;
                @(negedge clk);
                checks++;
                if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort: valid=%b busy=%b last=%b required 0 0 0", name, m_valid, busy, m_last);
                end
                rst = 1'b0;
                return;
            end
            obs  = {m_valid, busy, m_data, m_row, m_col, m_last};
            expv = {1'b1, 1'b1, exp_data[beat], exp_row[beat], exp_col[beat], exp_last[beat]};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL %s beat %0d: got %h required %h", name, beat, obs, expv);
            end
            if (stalled) begin
                checks++;
                if (obs !== held) begin
                    errors++;
                    $display("FAIL %s stall-hold beat %0d: got %h required %h", name, beat, obs, held);
                end
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2) finish_in = 1'($urandom_range(0, 1));
            if (corrupt && beat == 5) data_in = '1;
            m_ready = rdy;
            held    = obs;
            stalled = !rdy;
            if (rdy) beat++;
            cyc++;
            @(negedge clk);
        end
        m_ready   = 1'b0;
        finish_in = 1'b1;
        checks++;
        if (beat != SQU) begin
            errors++;
            $display("FAIL %s timeout: beats %0d required %0d", name, beat, SQU);
        end
        if (mode < 2) begin
            checks++;
            if (cyc != ((mode == 0) ? SQU : 2*SQU - 1)) begin
                errors++;
                $display("FAIL %s stream-cycles: got %0d required %0d", name, cyc, (mode == 0) ? SQU : 2*SQU - 1);
            end
        end
        checks++;
        if ({done, m_valid, busy, m_last} !== 4'b1000) begin
            errors++;
            $display("FAIL %s done-pulse: done/valid/busy/last=%b required 1000", name, {done, m_valid, busy, m_last});
        end
        @(negedge clk);
        checks++;
        if ({done, m_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL %s after-done: done/valid/busy=%b required 000", name, {done, m_valid, busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; finish_in = 1'b0; m_ready = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_row, m_col, m_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset-values: got %h required 0", {m_valid, m_data, m_row, m_col, m_last, busy, done});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset-idle: valid/busy/done=%b required 000", {m_valid, busy, done});
        end
    endtask

    task automatic test_hold_high();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL hold-high cycle %0d: valid=%b busy=%b required 0 0", i, m_valid, busy);
            end
        end
    endtask

    task automatic test_reset_edge();
        load_matrix(1'b1);
        build_expected();
        finish_in = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_row, m_col} !== {1'b1, exp_data[0], 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset-edge-start: got %h required %h", {m_valid, m_data, m_row, m_col}, {1'b1, exp_data[0], 8'd0});
        end
        rst = 1'b1; finish_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        load_matrix(1'b0);
        run_stream(0, -1, 1'b0, "full_ready");
        test_hold_high();
        run_stream(1, -1, 1'b0, "toggle_ready");
        run_stream(0, 50, 1'b0, "abort_run");
        run_stream(0, -1, 1'b0, "after_abort");
        run_stream(0, -1, 1'b1, "corrupt_input");
        load_matrix(1'b0);
        test_reset_edge();
        for (int k = 0; k < 3; k++) begin
            load_matrix(1'b1);
            run_stream(2, -1, 1'b0, "random_run");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
